// File: rtl/i2c_slave_ctrl.sv
// I2C slave transaction sequencer: walks address/data/ack phases from SCL edge pulses
// and steers the SDA shift register, output mux and RX/TX FIFO handshakes.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rising_edge_found,
  input  logic       falling_edge_found,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic [7:0] rx_data,
  input  logic       sda_in,
  input  logic       rx_fifo_full,
  input  logic       tx_fifo_empty,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       load_tx,
  output logic       rx_write,
  output logic [1:0] sda_mode,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, RX_DATA, ACK_DATA, NACK, LOAD, TX_DATA, MACK, WAIT_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       is_read_q, is_read_d;
  logic       mack_q, mack_d;
  logic       push;
  logic       rise, fall;

  // A rising pulse coincident with a falling pulse is treated as noise.
  assign rise = rising_edge_found & ~falling_edge_found;
  assign fall = falling_edge_found;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    is_read_d = is_read_q;
    mack_d    = mack_q;
    push      = 1'b0;
    if (stop_found) begin
      state_d = IDLE;
    end else if (start_found) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR: begin
          if (rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (fall && bit_cnt_q == 4'd8) begin
            if (rx_data[7:1] != SLAVE_ADDR) begin
              state_d = WAIT_STOP;
            end else begin
              is_read_d = rx_data[0];
              state_d   = (rx_data[0] && tx_fifo_empty) ? NACK : ACK_ADDR;
            end
          end
        end
        ACK_ADDR: if (fall) state_d = is_read_q ? LOAD : RX_DATA;
        RX_DATA: begin
          if (rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (fall && bit_cnt_q == 4'd8) begin
            if (rx_fifo_full) begin
              state_d = NACK;
            end else begin
              push    = 1'b1;
              state_d = ACK_DATA;
            end
          end
        end
        ACK_DATA: if (fall) state_d = RX_DATA;
        NACK:     if (fall) state_d = WAIT_STOP;
        LOAD:     state_d = TX_DATA;
        TX_DATA: begin
          if (rise) bit_cnt_d = bit_cnt_q + 4'd1;
          else if (fall && bit_cnt_q == 4'd8) state_d = MACK;
        end
        MACK: begin
          if (rise) mack_d = sda_in;
          else if (fall) state_d = (!mack_q && !tx_fifo_empty) ? LOAD : WAIT_STOP;
        end
        default: ;
      endcase
    end
    // Repeated START re-enters ADDR without a state change, so clear on it too.
    if (stop_found || start_found || state_d != state_q) bit_cnt_d = '0;
  end

  // Outputs are registered alongside the state so they follow the edge pulse by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      is_read_q <= 1'b0;
      mack_q    <= 1'b0;
      rx_enable <= 1'b0;
      tx_enable <= 1'b0;
      load_tx   <= 1'b0;
      rx_write  <= 1'b0;
      sda_mode  <= 2'd0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      is_read_q <= is_read_d;
      mack_q    <= mack_d;
      rx_enable <= (state_d == ADDR) || (state_d == RX_DATA);
      tx_enable <= (state_d == TX_DATA) && (bit_cnt_d != 4'd0);
      load_tx   <= (state_d == LOAD);
      rx_write  <= push;
      busy      <= (state_d != IDLE);
      case (state_d)
        ACK_ADDR, ACK_DATA: sda_mode <= 2'd1;
        NACK:               sda_mode <= 2'd2;
        TX_DATA:            sda_mode <= 2'd3;
        default:            sda_mode <= 2'd0;
      endcase
    end
  end

endmodule
